// File: rtl/wr_axi_pkg.sv
// Shared FSM encoding and AXI constants for the single-outstanding AXI write master.
package wr_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE is log2 of the bytes per beat; a full-width beat is always used.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; head valid whenever count is non-zero.
// Push is ignored when full and pop when empty; a simultaneous push and pop leaves the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok   = push_i && (count_q != FULL_CNT);
    assign pop_ok    = pop_i && (count_q != '0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == FULL_CNT);
    assign count_o   = count_q;

    // Storage is left unreset; readers gate the head with the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/wr_axi_master.sv
// AXI4 write master: buffers beats and burst commands, issues one INCR burst at a time once its data is fully buffered.
// AW/W/B wait on awready/wready/bvalid; upstream has no backpressure, so pushes into a full FIFO are dropped and flagged.
module wr_axi_master
    import wr_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int DATA_FIFO_DEPTH = 512,
    parameter int CMD_FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data_in,
    input  logic                        wr_data_valid,
    input  logic                        wr_data_last,
    input  logic                        wr_req_en,
    input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr_in,
    input  logic [7:0]                  wr_burst_len,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic                        data_fifo_full,
    output logic                        wr_busy,
    output logic                        wr_overflow,
    output logic                        wr_err
);
    localparam int DCNT_W = $clog2(DATA_FIFO_DEPTH) + 1;
    localparam int CCNT_W = $clog2(CMD_FIFO_DEPTH) + 1;
    localparam int CMD_W  = AXI_ADDR_WIDTH + 8;

    wr_state_e                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]                awlen_q, awlen_d;
    logic [7:0]                beat_q, beat_d;
    logic                      overflow_q, overflow_d;
    logic                      err_q, err_d;

    logic                      dfifo_full;
    logic                      dfifo_pop;
    logic [AXI_DATA_WIDTH-1:0] dfifo_head;
    logic [DCNT_W-1:0]         dfifo_count;
    logic                      data_avail;
    logic                      cfifo_full;
    logic                      cfifo_pop;
    logic [CMD_W-1:0]          cfifo_head;
    logic [CCNT_W-1:0]         cfifo_count;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]                cmd_len;
    logic [DCNT_W-1:0]         need_beats;
    logic                      unused_last;

    // Burst boundaries come from the command FIFO, so the upstream last flag is ignored.
    assign unused_last = wr_data_last;

    sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (DATA_FIFO_DEPTH)
    ) u_data_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (wr_data_valid),
        .push_dat_i (wr_data_in),
        .pop_i      (dfifo_pop),
        .pop_dat_o  (dfifo_head),
        .full_o     (dfifo_full),
        .count_o    (dfifo_count)
    );

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (wr_req_en),
        .push_dat_i ({wr_addr_in, wr_burst_len}),
        .pop_i      (cfifo_pop),
        .pop_dat_o  (cfifo_head),
        .full_o     (cfifo_full),
        .count_o    (cfifo_count)
    );

    assign cmd_addr   = cfifo_head[CMD_W-1:8];
    assign cmd_len    = cfifo_head[7:0];
    assign need_beats = DCNT_W'(cmd_len) + DCNT_W'(1);
    assign data_avail = (dfifo_count != '0);

    always_comb begin
        state_d       = state_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        beat_d        = beat_q;
        err_d         = err_q;
        cfifo_pop     = 1'b0;
        dfifo_pop     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Issue only when the whole burst is already buffered, so W never starves mid-burst.
                if ((cfifo_count != '0) && (dfifo_count >= need_beats)) begin
                    cfifo_pop = 1'b1;
                    awaddr_d  = cmd_addr;
                    awlen_d   = cmd_len;
                    state_d   = ST_AW;
                end
            end
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                m_axi_wvalid = data_avail;
                m_axi_wlast  = data_avail && (beat_q == awlen_q);
                if (data_avail && m_axi_wready) begin
                    dfifo_pop = 1'b1;
                    if (beat_q == awlen_q) begin
                        beat_d  = '0;
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_d = ST_IDLE;
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign overflow_d = overflow_q || (wr_data_valid && dfifo_full) || (wr_req_en && cfifo_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign m_axi_awaddr   = awaddr_q;
    assign m_axi_awlen    = awlen_q;
    assign m_axi_awsize   = axi_size(AXI_DATA_WIDTH);
    assign m_axi_awburst  = AXI_BURST_INCR;
    assign m_axi_wstrb    = '1;
    assign m_axi_wdata    = m_axi_wvalid ? dfifo_head : '0;
    assign data_fifo_full = dfifo_full;
    assign wr_busy        = (state_q != ST_IDLE);
    assign wr_overflow    = overflow_q;
    assign wr_err         = err_q;

endmodule
